alu_arbiter: RTL
================

# alu_arbiter

Shares the single ALU (ALU control decoder plus ALU datapath) between two requesters: port 0 (main execute stage) and port 1 (address/branch unit). The arbiter picks one pending request with round-robin priority and latches its ALUOp/Funct/OPCode and operands into registers that drive the ALU. It captures the ALU result and flags, then returns them to the winner with a one-cycle Done pulse. It sits between the requesters and the ALUControl/ALU pair, which stay purely combinational.

## Interface
- WIDTH, 16, operand/result width in bits

- Clock  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- Req0, Req1  input  1 each  request from port 0 / port 1; held high until that port's Done
- ALUOp0, ALUOp1  input  2 each  ALUOp of each requester
- Funct0, Funct1  input  2 each  Funct of each requester
- OPCode0, OPCode1  input  4 each  OPCode of each requester
- A0, B0, A1, B1  input  WIDTH each  operands of each requester
- AluALUOp  output  2  registered ALUOp to ALU control
- AluFunct  output  2  registered Funct to ALU control
- AluOPCode  output  4  registered OPCode to ALU control
- AluA, AluB  output  WIDTH each  registered operands to ALU
- AluResult  input  WIDTH  combinational ALU result
- AluZero  input  1  combinational ALU zero flag
- Result  output  WIDTH  captured result, valid while Done0 or Done1 is high
- Zero  output  1  captured zero flag, valid with Result
- Done0, Done1  output  1 each  one-cycle completion pulse to the winner
- Busy  output  1  high in ISSUE and DONE

## Operation
- States: IDLE, ISSUE, DONE. Reset state is IDLE.
- IDLE:
  - No Req high: stay in IDLE.
  - Any Req high: select a winner, latch its ALUOp/Funct/OPCode/A/B into the Alu* registers, store GrantId, go to ISSUE.
- Winner selection: a single request always wins. When both are high, grant the port opposite LastGrant, then update LastGrant to the winner. Reset value of LastGrant is 1, so port 0 wins the first contention.
- ISSUE: the ALU evaluates from the registered Alu* outputs. At the clock edge, capture AluResult into Result and AluZero into Zero, then go to DONE.
- DONE: assert Done[GrantId] for exactly one cycle. Req is ignored in DONE. Unconditionally go to IDLE.
- Code fields are forwarded unmodified. The arbiter does not check for code combinations the ALU control leaves undecoded (for example ALUOp=10 with Funct=11); the result for those is whatever the ALU produces.
- Alu* registers keep their last value in IDLE and DONE. They change only on a grant.
- Result and Zero keep their last captured value until the next ISSUE→DONE edge.
- Requester rule: drop Req on the edge that ends its Done cycle. If Req is still high in the following IDLE, it counts as a new request.
- A requester that drops Req while the other port is in flight loses nothing. A requester that drops Req before being granted withdraws its request.
- Reset (any time, including mid-ISSUE or mid-DONE): state←IDLE; all outputs, Alu* registers, Result, Zero, GrantId ←0; LastGrant←1. The in-flight transaction is dropped and no Done is issued.

## Timing
- Latency: Req high in IDLE cycle n → ISSUE in n+1 → Done and Result valid in n+2.
- Throughput: one operation per 3 cycles. Back-to-back grants are possible with IDLE at n+3.
- With both ports requesting continuously: grants alternate 0,1,0,1…, each port served every 6 cycles.
- Done0 and Done1 are never high together. Busy = (state≠IDLE).
- All outputs are registered. There is no combinational path from Req* or operands to any output.
- AluResult must settle within one cycle of Alu* update; this is the ALU critical path.

## Test plan
- Reset then single request: Req0=1, ALUOp0=00, A0=5, B0=3 → Alu* updated at n+1, Done0=1, Result=8, Zero=0 at n+2, Done1 never high.
- Simultaneous first contention: Req0=Req1=1 from reset, port 0 SUB 7−7, port 1 AND 0xF0F0&0x0FF0 → Done0 with Result=0, Zero=1 first; 3 cycles later Done1 with Result=0x00F0.
- Sustained contention: both Req held high with re-assertion after each Done over 8 grants → grant order 0,1,0,1,0,1,0,1, each Done spaced 3 cycles apart.
- Late arrival: Req1 rises during port 0's ISSUE → no effect on in-flight op, Done0 at its cycle, port 1 granted at the next IDLE.
- Reset mid-operation: Reset_n low during ISSUE → Busy, Done0, Done1, Result, Zero and Alu* all 0 immediately; after release, IDLE and first contention goes to port 0.
- Opcode pass-through: Req1 with ALUOp=11, OPCode=1011, Funct=00 → AluALUOp=11, AluOPCode=1011 at n+1, Done1 at n+2.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters.
// Ports:
//   Clock, Reset_n                  rising-edge clock, async active-low reset
//   Req0/1, ALUOp0/1, Funct0/1,
//   OPCode0/1, A0/1, B0/1           per-port request, code fields and operands
//   AluALUOp, AluFunct, AluOPCode,
//   AluA, AluB                      registered fields/operands driving the ALU
//   AluResult, AluZero              combinational ALU outputs fed back in
//   Result, Zero                    captured result/flag, valid with Done*
//   Done0, Done1                    one-cycle completion pulse to the winner
//   Busy                            high while an operation is in flight
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [1:0]       ALUOp0,
  input  logic [1:0]       ALUOp1,
  input  logic [1:0]       Funct0,
  input  logic [1:0]       Funct1,
  input  logic [3:0]       OPCode0,
  input  logic [3:0]       OPCode1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic [1:0]       AluALUOp,
  output logic [1:0]       AluFunct,
  output logic [3:0]       AluOPCode,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluZero,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Done0,
  output logic             Done1,
  output logic             Busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [1:0]       alu_funct_q, alu_funct_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             grant, win, capture;
  always_comb begin
    grant        = (state_q == IDLE) && (Req0 || Req1);
    // contention goes to the port that did not win last; a lone request always wins
    win          = (Req0 && Req1) ? ~last_grant_q : Req1;
    capture      = (state_q == ISSUE);
    state_d      = capture ? DONE : grant ? ISSUE : IDLE;
    last_grant_d = grant ? win : last_grant_q;
    grant_id_d   = grant ? win : grant_id_q;
    alu_op_d     = grant ? (win ? ALUOp1 : ALUOp0) : alu_op_q;
    alu_funct_d  = grant ? (win ? Funct1 : Funct0) : alu_funct_q;
    alu_opcode_d = grant ? (win ? OPCode1 : OPCode0) : alu_opcode_q;
    alu_a_d      = grant ? (win ? A1 : A0) : alu_a_q;
    alu_b_d      = grant ? (win ? B1 : B0) : alu_b_q;
    result_d     = capture ? AluResult : result_q;
    zero_d       = capture ? AluZero : zero_q;
    done0_d      = capture && !grant_id_q;
    done1_d      = capture && grant_id_q;
    busy_d       = (state_d != IDLE);
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      alu_op_q     <= '0;
      alu_funct_q  <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      alu_op_q     <= alu_op_d;
      alu_funct_q  <= alu_funct_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
    end
  end
  assign AluALUOp  = alu_op_q;
  assign AluFunct  = alu_funct_q;
  assign AluOPCode = alu_opcode_q;
  assign AluA      = alu_a_q;
  assign AluB      = alu_b_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Done0     = done0_q;
  assign Done1     = done1_q;
  assign Busy      = busy_q;
endmodule
